// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin resource arbiter.
// Imported by the arbiter top and any arbiter reusing rr_pick.
package arb_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_RELEASE
    } arb_state_e;

    function automatic logic [3:0] onehot_to_idx(
        input logic [MAX_REQ-1:0] oh
    );
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after ptr,
// wrapping from N_REQ-1 back to 0. Purely combinational.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    // Scan from the farthest offset down so the nearest request wins.
    always_comb begin
        int sum;
        logic [IDX_W-1:0] j;
        sum     = 0;
        j       = '0;
        winner  = '0;
        any_req = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            sum = int'(ptr) + i;
            if (sum >= N_REQ) sum = sum - N_REQ;
            j = IDX_W'(sum);
            if (req[j]) winner = j;
        end
    end

endmodule

// File: rtl/rr_resource_arbiter.sv
// Round-robin owner of a single-ported resource: one grant at a time,
// held until done, abandon, or hold timeout; one bubble after release.
module rr_resource_arbiter
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_i,
    input  logic                     done_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] gnt_idx_o,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int HW    = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] PTR_LAST  = IDX_W'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             tmo_q, tmo_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_i),
        .ptr     (ptr_q),
        .winner  (pick_idx),
        .any_req (pick_any)
    );

    // Next-state and next-output decode; illegal states fall back to idle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        tmo_d   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_GRANT;
                    gnt_d   = N_REQ'(1) << pick_idx;
                    idx_d   = IDX_W'(onehot_to_idx(MAX_REQ'(gnt_d)));
                    ptr_d   = (pick_idx == PTR_LAST) ? '0
                                                     : pick_idx + 1'b1;
                    hold_d  = '0;
                end
            end
            ARB_GRANT: begin
                hold_d = (hold_q == '1) ? hold_q : hold_q + 1'b1;
                if (done_i || !(|(req_i & gnt_q))) begin
                    state_d = ARB_RELEASE;
                    gnt_d   = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ARB_RELEASE;
                    gnt_d   = '0;
                    tmo_d   = 1'b1;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
                idx_d   = '0;
                ptr_d   = '0;
                hold_d  = '0;
                tmo_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any grant silently.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_idx_o = idx_q;
    assign busy_o    = (state_q == ARB_GRANT);
    assign timeout_o = tmo_q;

endmodule
